// File: rtl/project.sv
// project: 16-bit single-cycle CPU running a fixed ROM program. Its output port drives LEDs, a
// multiplexed 4-digit seven-segment display and, when PROJECT_UART_EN is defined, an 8N1 UART.

module project_regfile #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [2:0]           wa,
  input  logic [WORD_SIZE-1:0] wd,
  input  logic [2:0]           ra_s,
  input  logic [2:0]           ra_t,
  input  logic [2:0]           ra_d,
  output logic [WORD_SIZE-1:0] rs_val,
  output logic [WORD_SIZE-1:0] rt_val,
  output logic [WORD_SIZE-1:0] rd_val
);
  logic [WORD_SIZE-1:0] reg_file [0:7] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) reg_file[i] <= '0;
    end else if (we) begin
      reg_file[wa] <= wd;
    end
  end

  assign rs_val = reg_file[ra_s];
  assign rt_val = reg_file[ra_t];
  assign rd_val = reg_file[ra_d];
endmodule

module project_datapath #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [15:0]          instr,
  input  logic [3:0]           bt,
  input  logic                 reg_we,
  input  logic                 is_jmp,
  input  logic                 is_bz,
  input  logic                 is_out,
  input  logic                 is_halt,
  output logic [7:0]           pc,
  output logic [WORD_SIZE-1:0] out_reg,
  output logic [WORD_SIZE-1:0] rs_val,
  output logic                 halted
);
  logic [7:0]           pc_r = '0;
  logic [WORD_SIZE-1:0] out_r = '0;
  logic                 halted_r = 1'b0;
  logic [WORD_SIZE-1:0] rt_val, rd_val, result, imm6_sx;
  logic [7:0]           pc_next;

  project_regfile #(.WORD_SIZE(WORD_SIZE)) registers (
    .clk    (clk),
    .rst    (rst),
    .we     (run & reg_we),
    .wa     (instr[11:9]),
    .wd     (result),
    .ra_s   (instr[8:6]),
    .ra_t   (instr[5:3]),
    .ra_d   (instr[11:9]),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .rd_val (rd_val)
  );

  assign imm6_sx = {{(WORD_SIZE-6){instr[5]}}, instr[5:0]};

  always_comb begin
    result = '0;
    case (instr[15:12])
      4'h1:    result = rs_val + rt_val;
      4'h2:    result = rs_val - rt_val;
      4'h3:    result = rs_val & rt_val;
      4'h4:    result = rs_val | rt_val;
      4'h5:    result = rs_val ^ rt_val;
      4'h6:    result = rs_val << 1;
      4'h7:    result = rs_val >> 1;
      4'h8:    result = rs_val + imm6_sx;
      4'h9:    result = WORD_SIZE'(instr[8:0]);
      4'hD:    result = WORD_SIZE'(bt);
      default: result = '0;
    endcase
  end

  // Branch offset is sign-extended, but the 8-bit PC wraps, so a plain 8-bit add is exact.
  always_comb begin
    pc_next = pc_r + 8'd1;
    if (is_jmp)                       pc_next = instr[7:0];
    else if (is_bz && rd_val == '0)   pc_next = pc_r + 8'd1 + instr[7:0];
    else if (is_halt)                 pc_next = pc_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= '0;
      out_r    <= '0;
      halted_r <= 1'b0;
    end else if (run) begin
      pc_r <= pc_next;
      if (is_out)  out_r    <= rs_val;
      if (is_halt) halted_r <= 1'b1;
    end
  end

  assign pc      = pc_r;
  assign out_reg = out_r;
  assign halted  = halted_r;
endmodule

module project_cpu #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pause,
  input  logic [3:0]           bt,
  output logic [WORD_SIZE-1:0] out_reg,
  output logic                 out_fire,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 halted
);
  logic [7:0]  pc;
  logic [15:0] instr;
  logic        run, reg_we, is_jmp, is_bz, is_out, is_halt;

  assign run = ~pause;

  always_comb begin
    case (pc)
      8'd0:    instr = 16'h9201;
      8'd1:    instr = 16'h9400;
      8'd2:    instr = 16'h1488;
      8'd3:    instr = 16'hC080;
      8'd4:    instr = 16'hA002;
      default: instr = 16'h0000;
    endcase
  end

  always_comb begin
    reg_we  = 1'b0;
    is_jmp  = 1'b0;
    is_bz   = 1'b0;
    is_out  = 1'b0;
    is_halt = 1'b0;
    case (instr[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
      4'h6, 4'h7, 4'h8, 4'h9, 4'hD: reg_we = 1'b1;
      4'hA:    is_jmp  = 1'b1;
      4'hB:    is_bz   = 1'b1;
      4'hC:    is_out  = 1'b1;
      4'hE:    is_halt = 1'b1;
      default: ;
    endcase
  end

  project_datapath #(.WORD_SIZE(WORD_SIZE)) datapath (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .instr   (instr),
    .bt      (bt),
    .reg_we  (reg_we),
    .is_jmp  (is_jmp),
    .is_bz   (is_bz),
    .is_out  (is_out),
    .is_halt (is_halt),
    .pc      (pc),
    .out_reg (out_reg),
    .rs_val  (out_data),
    .halted  (halted)
  );

  assign out_fire = run & is_out;
endmodule

module project_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state = IDLE;
  state_t           state_next;
  logic [CNT_W-1:0] cnt   = '0;
  logic [2:0]       bitn  = '0;
  logic [7:0]       shreg = '0;
  logic             bit_done;

  assign bit_done = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A start request outside IDLE is simply ignored: the byte is dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = START;
      START:   if (bit_done) state_next = DATA;
      DATA:    if (bit_done && bitn == 3'd7) state_next = STOP;
      STOP:    if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else if (state == IDLE) begin
      cnt  <= '0;
      bitn <= '0;
      if (start) shreg <= data;
    end else if (bit_done) begin
      cnt <= '0;
      if (state == DATA) begin
        shreg <= shreg >> 1;
        bitn  <= bitn + 3'd1;
      end
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shreg[0];
      default: tx = 1'b1;
    endcase
  end
endmodule

module project_hex7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  // Active-low {g,f,e,d,c,b,a}.
  always_comb begin
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end
endmodule

module project_display #(
  parameter int REFRESH_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [7:0]  seg,
  output logic [3:0]  dig
);
  logic [REFRESH_BITS+1:0] scan = '0;
  logic [1:0]              sel;
  logic [3:0][3:0]         nib;
  logic [3:0][6:0]         glyph;

  always_ff @(posedge clk) begin
    if (rst) scan <= '0;
    else     scan <= scan + (REFRESH_BITS+2)'(1);
  end

  assign sel = scan[REFRESH_BITS+1 -: 2];
  assign nib = value;

  project_hex7 u_hex [3:0] (.nib(nib), .seg(glyph));

  assign seg = {1'b1, glyph[sel]};
  assign dig = ~(4'b0001 << sel);
endmodule

module project #(
  parameter int WORD_SIZE    = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int REFRESH_BITS = 16
) (
  output logic [3:0] led,
  output logic [7:0] seg,
  output logic [3:0] dig,
  input  logic [3:0] bt,
  input  logic       clk,
  input  logic       rx,
  output logic       tx
);
  logic                 rst;
  logic [WORD_SIZE-1:0] out_reg, out_data;
  logic                 out_fire, halted;

  assign rst = bt[0];

  project_cpu #(.WORD_SIZE(WORD_SIZE)) cpu (
    .clk      (clk),
    .rst      (rst),
    .pause    (bt[1]),
    .bt       (bt),
    .out_reg  (out_reg),
    .out_fire (out_fire),
    .out_data (out_data),
    .halted   (halted)
  );

  assign led = out_reg[3:0];

  project_display #(.REFRESH_BITS(REFRESH_BITS)) display (
    .clk   (clk),
    .rst   (rst),
    .value (out_reg[15:0]),
    .seg   (seg),
    .dig   (dig)
  );

`ifdef PROJECT_UART_EN
  project_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uart (
    .clk   (clk),
    .rst   (rst),
    .start (out_fire),
    .data  (out_data[7:0]),
    .tx    (tx)
  );
`else
  assign tx = 1'b1;
`endif

  // rx and halted have no consumer; the UART-less build also leaves the OUT data unused.
  logic unused_ok;
  assign unused_ok = ^{rx, out_data, out_fire, halted, CLKS_PER_BIT[0]};
endmodule

// File: tb/tb_project.sv
// tb_project: randomized buttons against an ISA-level model of the program, UART frame timing
// and display scan; compares LEDs, display, tx, PC, r1/r2 and out_reg every cycle.

module tb_project;
  localparam int CPB = 4;
  localparam int RB  = 2;

  logic [3:0] led, dig, bt;
  logic [7:0] seg;
  logic       clk = 1'b0;
  logic       rx  = 1'b1;
  logic       tx;

  project #(.WORD_SIZE(16), .CLKS_PER_BIT(CPB), .REFRESH_BITS(RB)) dut (
    .led(led), .seg(seg), .dig(dig), .bt(bt), .clk(clk), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] rom [256];
  logic [15:0] m_r [8];
  logic [15:0] m_out;
  int          m_pc, m_scan, m_t;
  logic [7:0]  m_byte;
  logic [7:0]  glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_out  = '0;
    m_pc   = 0;
    m_scan = 0;
    m_t    = -1;
    m_byte = '0;
  endtask

  // One rising edge with buttons b; m_t counts clocks since the current frame started.
  task automatic model_step(input logic [3:0] b);
    logic [15:0] ins, a, c;
    int op, rd, rs, rt, npc;
    bit busy_old, fire;
    if (b[0]) begin
      model_reset();
      return;
    end
    m_scan   = (m_scan + 1) % (4 << RB);
    busy_old = (m_t >= 0);
    if (busy_old) begin
      m_t++;
      if (m_t == 10 * CPB) m_t = -1;
    end
    if (b[1]) return;
    ins  = rom[m_pc];
    op   = int'(ins[15:12]);
    rd   = int'(ins[11:9]);
    rs   = int'(ins[8:6]);
    rt   = int'(ins[5:3]);
    a    = m_r[rs];
    c    = m_r[rt];
    npc  = (m_pc + 1) % 256;
    fire = 0;
    case (op)
      1:  m_r[rd] = a + c;
      2:  m_r[rd] = a - c;
      3:  m_r[rd] = a & c;
      4:  m_r[rd] = a | c;
      5:  m_r[rd] = a ^ c;
      6:  m_r[rd] = a << 1;
      7:  m_r[rd] = a >> 1;
      8:  m_r[rd] = a + {{10{ins[5]}}, ins[5:0]};
      9:  m_r[rd] = {7'b0, ins[8:0]};
      10: npc = int'(ins[7:0]);
      11: if (m_r[rd] == 16'h0) npc = (m_pc + 1 + int'($signed(ins[7:0]))) & 255;
      12: begin m_out = a; fire = 1; end
      13: m_r[rd] = {12'b0, b};
      14: npc = m_pc;
      default: ;
    endcase
    m_pc = npc;
    if (fire && !busy_old) begin
      m_t    = 0;
      m_byte = a[7:0];
    end
  endtask

  function automatic logic exp_tx();
`ifdef PROJECT_UART_EN
    int idx;
    if (m_t < 0) return 1'b1;
    idx = m_t / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_all();
    int k;
    logic [3:0] edig;
    logic [3:0] enib;
    k    = (m_scan >> RB) & 3;
    edig = 4'hF;
    edig[k] = 1'b0;
    enib = m_out[4*k +: 4];
    chk("led", led, m_out[3:0]);
    chk("dig", dig, edig);
    chk("seg", seg, glyph[enib]);
    chk("tx", tx, exp_tx());
    chk("pc", dut.cpu.datapath.pc, m_pc);
    chk("r1", dut.cpu.datapath.registers.reg_file[1], m_r[1]);
    chk("r2", dut.cpu.datapath.registers.reg_file[2], m_r[2]);
    chk("out_reg", dut.cpu.datapath.out_reg, m_out);
  endtask

  task automatic cycle(input logic [3:0] b);
    bt = b;
    @(posedge clk);
    model_step(b);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [3:0] b;
    logic [1:0] hi;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h9201;
    rom[1] = 16'h9400;
    rom[2] = 16'h1488;
    rom[3] = 16'hC080;
    rom[4] = 16'hA002;
    model_reset();
    bt = 4'h0;
    #1;
    check_all();                      // power-up state
    repeat (3) cycle(4'h0);
    cycle(4'h1);                      // one-cycle reset pulse
    for (int i = 0; i < 8; i++) chk("rst_reg", dut.cpu.datapath.registers.reg_file[i], 32'h0);
    repeat (60) cycle(4'h0);          // two UART frames, OUTs in between dropped
    cycle(4'h1);                      // reset while a frame is in flight
    repeat (20) cycle(4'h0);
    repeat (10) cycle(4'h2);          // pause
    repeat (20) cycle(4'h0);
    repeat (700) begin
      hi   = 2'($urandom);
      b    = {hi, 2'b00};
      b[1] = ($urandom_range(0, 3) == 0);
      b[0] = ($urandom_range(0, 63) == 0);
      cycle(b);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/project.md
# project

Top-level FPGA design: a 16-bit single-cycle CPU (`cpu`) with an 8×16-bit register file (`cpu.datapath.registers.reg_file[0..7]`) runs a fixed program from an on-chip ROM. Its output port drives four LEDs, a 4-digit multiplexed seven-segment display and a UART transmitter. Pushbuttons provide reset, pause and an input port.

## Interface
Parameters:
- `WORD_SIZE`, 16: datapath and register width.
- `CLKS_PER_BIT`, 434: UART bit period in clocks; must be ≥2.
- `REFRESH_BITS`, 16: display scan counter width; the digit advances when the low `REFRESH_BITS` bits wrap.

Ports (order: led, seg, dig, bt, clk, rx, tx). One clock; reset is synchronous and active-high.
- `clk`: input, 1 bit. System clock; all state changes on the rising edge.
- `bt`: input, 4 bits. `bt[0]` is the synchronous active-high reset. `bt[1]` pauses the CPU when 1. `bt[3:0]` is also read by the `IN` instruction.
- `led`: output, 4 bits. Equal to `out_reg[3:0]`.
- `seg`: output, 8 bits. Active-low segments `{dp,g,f,e,d,c,b,a}`. `dp` is always 1.
- `dig`: output, 4 bits. Active-low digit enables; exactly one bit is 0.
- `rx`: input, 1 bit. UART receive; ignored.
- `tx`: output, 1 bit. UART transmit, 8N1, LSB first; idles at 1.

## Operation
- State: 8-bit PC; `reg_file[0..7]`, all general-purpose (r0 is writable); 16-bit `out_reg`; `halted` flag.
- Instruction fields: `op=[15:12]`, `rd=[11:9]`, `rs=[8:6]`, `rt=[5:3]`, `imm6=[5:0]`, `imm9=[8:0]`, `imm12=[11:0]`.
- ROM: 256×16, combinational read at PC. Unlisted words are 0x0000.
- Opcodes. PC advances by +1 except for jumps, taken branches and HALT:
  - 0 NOP
  - 1 ADD: rd = rs + rt
  - 2 SUB: rd = rs − rt
  - 3 AND, 4 OR, 5 XOR: rd = rs op rt
  - 6 SHL: rd = rs << 1
  - 7 SHR: rd = rs >> 1, logical
  - 8 ADDI: rd = rs + sext(imm6)
  - 9 LI: rd = zext(imm9)
  - A JMP: PC = imm12[7:0]
  - B BZ: if rd == 0 then PC = PC + 1 + sext(imm9[7:0])
  - C OUT: out_reg = rs, and start a UART send of rs[7:0]
  - D IN: rd = {12'b0, bt}
  - E HALT: PC holds, `halted` = 1
  - F: NOP
- Arithmetic is modulo 2^16; the PC wraps modulo 256.
- ROM contents:
  - 0: `0x9201` LI r1,1
  - 1: `0x9400` LI r2,0
  - 2: `0x1488` ADD r2,r2,r1
  - 3: `0xC080` OUT r2
  - 4: `0xA002` JMP 2
- UART: OUT while the transmitter is busy drops the byte; `out_reg` still updates.
- Display:
  - Digit k (`dig[k]` = 0) shows hex nibble `out_reg[4k+3:4k]`.
  - Scan order: k = 0, 1, 2, 3, then 0 again.
  - Standard hex glyphs, active-low; for example 0 → `seg=0xC0` and 1 → `seg=0xF9`.

## Timing
- Reset: while `bt[0]`=1 at a rising edge, the next state is:
  - PC = 0, all registers = 0, `out_reg` = 0, `halted` = 0;
  - UART idle with `tx` = 1;
  - scan counter = 0, so `dig` = `4'b1110`;
  - `led` = 0, `seg` = `0xC0`.
- Reset overrides pause, HALT and an in-progress UART frame; the frame aborts and `tx` returns to 1 immediately.
- Power-up: all state has the same initial values as reset, so the design runs without a reset pulse.
- Execution: one instruction per clock. Register, PC and `out_reg` writes happen at the rising edge that ends the instruction's cycle.
- Pause: while `bt[1]`=1 (and `bt[0]`=0), the PC, registers and `out_reg` hold. The UART and display keep running.
- UART frame: starts at the edge that executes OUT.
  - Start bit, then 8 data bits, then the stop bit, each lasting `CLKS_PER_BIT` clocks.
  - Busy lasts 10×`CLKS_PER_BIT` clocks; a new OUT is accepted on the cycle busy clears.
- Buttons are used raw; there is no debounce.

## Configuration
- `PROJECT_UART_EN`:
  - Defined: the UART transmitter is built as specified.
  - Undefined: no transmitter logic; `tx` is constant 1 and OUT affects only `out_reg`.

## Test plan
- Pulse `bt[0]` for 1 cycle, then release: PC = 0, all `reg_file` = 0, `led` = 0, `dig` = 1110, `tx` = 1.
- 5 cycles after reset release: r1 = 1, r2 = 1, `out_reg` = 1, `led` = 0001.
- 2+3n cycles after reset release (for example 32): r2 = n, and `out_reg` = n once the following OUT executes.
- Hold `bt[1]` high for 10 cycles mid-run: r2 and PC are unchanged, then counting resumes.
- With `CLKS_PER_BIT`=4 and the macro defined: after the first OUT, `tx` shows 0, 1, 0,0,0,0,0,0,0, 1 at 4 cycles per bit (byte 0x01); a second OUT arriving during the frame is dropped.
- With `REFRESH_BITS`=2: `dig` cycles 1110 → 1101 → 1011 → 0111 every 4 clocks, and `seg` matches the glyph of the corresponding `out_reg` nibble.
